// File: rtl/fds_snd_filter.sv
// FDS output RC filter model: first-order IIR low-pass (alpha = 2^-SHIFT) updated every DIV clocks,
// with a registered sample for the mixer and a first-order sigma-delta bitstream for a pin.
module fds_snd_filter #(
    parameter int W     = 12,
    parameter int DIV   = 24,
    parameter int SHIFT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] snd_in,
    input  logic         bypass,
    output logic [W-1:0] snd_out,
    output logic         smp_stb,
    output logic         pdm_out
);

    localparam int AW = W + SHIFT;

    // acc holds y * 2^SHIFT; subtracting first keeps the sum inside AW bits
    function automatic logic [AW-1:0] iir_step(input logic [AW-1:0] a, input logic [W-1:0] x);
        return a - (a >> SHIFT) + AW'(x);
    endfunction

    function automatic logic [W-1:0] trunc_y(input logic [AW-1:0] a);
        return W'(a >> SHIFT);
    endfunction

    logic [15:0]   div_ctr;
    logic          upd;

    logic [W-1:0]  x_p0;
    logic          byp_p0;
    logic          vld_p0;

    logic [AW-1:0] acc;
    logic [W-1:0]  x_p1;
    logic          byp_p1;
    logic          vld_p1;

    logic [W:0]    pdm_acc;
    logic [W:0]    pdm_sum;

    assign upd = (div_ctr == 16'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ctr <= '0;
        end else if (upd) begin
            div_ctr <= '0;
        end else begin
            div_ctr <= div_ctr + 16'd1;
        end
    end

    // Stage p0: capture the input sample and bypass mode at the update tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p0   <= '0;
            byp_p0 <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= upd;
            if (upd) begin
                x_p0   <= snd_in;
                byp_p0 <= bypass;
            end
        end
    end

    // Stage p1: filter update; the filter keeps tracking even while bypassed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            x_p1   <= '0;
            byp_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                acc    <= iir_step(acc, x_p0);
                x_p1   <= x_p0;
                byp_p1 <= byp_p0;
            end
        end
    end

    // Stage p2: output register, loaded in the cycle the strobe is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_out <= '0;
        end else if (vld_p1) begin
            snd_out <= byp_p1 ? x_p1 : trunc_y(acc);
        end
    end

    assign smp_stb = vld_p1;

    // Sigma-delta runs every clock; the carry out of the add is the output bit
    assign pdm_sum = {1'b0, pdm_acc[W-1:0]} + (W+1)'(snd_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdm_acc <= '0;
        end else begin
            pdm_acc <= pdm_sum;
        end
    end

    assign pdm_out = pdm_acc[W];

endmodule

// File: tb/tb_fds_snd_filter.sv
// Directed bench for fds_snd_filter: step response, strobe timing, bypass, PDM density,
// asynchronous mid-pipeline reset, full-scale convergence and the DIV=1/SHIFT=0 passthrough.
module tb_fds_snd_filter;

    logic        clk;
    logic        rst;
    logic [11:0] snd_in;
    logic        bypass;
    logic [11:0] snd_out;
    logic        smp_stb;
    logic        pdm_out;

    logic [11:0] snd_in1;
    logic        bypass1;
    logic [11:0] snd_out1;
    logic        smp_stb1;
    logic        pdm_out1;

    int checks = 0;
    int errors = 0;

    fds_snd_filter #(.W(12), .DIV(24), .SHIFT(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .snd_in  (snd_in),
        .bypass  (bypass),
        .snd_out (snd_out),
        .smp_stb (smp_stb),
        .pdm_out (pdm_out)
    );

    fds_snd_filter #(.W(12), .DIV(1), .SHIFT(0)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .snd_in  (snd_in1),
        .bypass  (bypass1),
        .snd_out (snd_out1),
        .smp_stb (smp_stb1),
        .pdm_out (pdm_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts clock edges until smp_stb is seen high (sampled 1ns after the edge)
    task automatic wait_stb(output int n);
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            found = smp_stb;
        end
        chk("stb_seen", {31'd0, found}, 32'd1);
    endtask

    // The value snd_out takes at the end of the strobe cycle
    task automatic next_val(output logic [11:0] v);
        @(posedge clk);
        #1;
        v = snd_out;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int ones;
        int bad;
        int bad2;
        logic [11:0] v;
        logic [11:0] prev;
        logic        reached;
        logic [11:0] hist [0:63];
        logic        pdm_hist [0:63];

        rst     = 1'b1;
        snd_in  = '0;
        bypass  = 1'b0;
        snd_in1 = '0;
        bypass1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_snd_out", 32'(snd_out), 32'd0);
        chk("rst_smp_stb", 32'(smp_stb), 32'd0);
        chk("rst_pdm_out", 32'(pdm_out), 32'd0);

        // Zero input: filter stays at 0 and the bitstream never goes high
        @(negedge clk);
        rst  = 1'b0;
        ones = 0;
        bad  = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (pdm_out) ones++;
            if (snd_out != 12'd0) bad++;
        end
        chk("pdm_zero_ones", 32'(ones), 32'd0);
        chk("zero_snd_out", 32'(bad), 32'd0);

        // Step response at 0x800
        snd_in = 12'h800;
        do_reset();
        wait_stb(n);
        chk("first_stb_latency", 32'(n), 32'd25);
        next_val(v);
        chk("stb_single_cycle", 32'(smp_stb), 32'd0);
        chk("step_y1", 32'(v), 32'd128);
        wait_stb(n);
        chk("stb_interval_1", 32'(n + 1), 32'd24);
        next_val(v);
        chk("step_y2", 32'(v), 32'd248);
        wait_stb(n);
        chk("stb_interval_2", 32'(n + 1), 32'd24);
        next_val(v);
        chk("step_y3", 32'(v), 32'd360);

        // Asynchronous reset while the next update sits in stage p0
        repeat (22) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_snd_out", 32'(snd_out), 32'd0);
        chk("midrst_smp_stb", 32'(smp_stb), 32'd0);
        chk("midrst_pdm_out", 32'(pdm_out), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_no_stale_stb", 32'(smp_stb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_stb(n);
        chk("midrst_release_latency", 32'(n), 32'd25);
        next_val(v);
        chk("midrst_restart_y1", 32'(v), 32'd128);

        // Bypass from a zero filter state, then resume from the tracked state
        snd_in = 12'h321;
        bypass = 1'b1;
        do_reset();
        wait_stb(n);
        next_val(v);
        chk("bypass_value", 32'(v), 32'h321);
        bypass = 1'b0;
        wait_stb(n);
        next_val(v);
        chk("unbypass_tracked", 32'(v), 32'd97);
        bypass = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bypass = 1'b0;
        wait_stb(n);
        next_val(v);
        chk("bypass_glitch_ignored", 32'(v), 32'd141);

        // Steady 0x400 through bypass: one PDM one every four clocks
        bypass = 1'b1;
        snd_in = 12'h400;
        wait_stb(n);
        next_val(v);
        chk("pdm_level", 32'(v), 32'h400);
        repeat (2) @(posedge clk);
        ones = 0;
        bad  = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            pdm_hist[i] = pdm_out;
            if (pdm_out) ones++;
            if (i >= 4 && pdm_hist[i] != pdm_hist[i-4]) bad++;
        end
        chk("pdm_quarter_ones", 32'(ones), 32'd16);
        chk("pdm_period4", 32'(bad), 32'd0);

        // Full-scale input for 400 updates
        bypass  = 1'b0;
        snd_in  = 12'hFFF;
        do_reset();
        prev    = '0;
        reached = 1'b0;
        bad     = 0;
        bad2    = 0;
        for (int i = 0; i < 400; i++) begin
            wait_stb(n);
            next_val(v);
            if (v < prev) bad++;
            if (reached && v != 12'hFFF) bad2++;
            if (v == 12'hFFF) reached = 1'b1;
            prev = v;
        end
        chk("fullscale_monotonic", 32'(bad), 32'd0);
        chk("fullscale_final", 32'(prev), 32'hFFF);
        chk("fullscale_holds", 32'(bad2), 32'd0);

        // DIV=1, SHIFT=0 instance: ramp passes through, strobe continuous
        snd_in1 = 12'h100;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        hist[0] = snd_in1;
        bad     = 0;
        bad2    = 0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) chk("div1_stb_fill", 32'(smp_stb1), 32'd0);
            if (j >= 2 && !smp_stb1) bad++;
            if (j >= 3 && snd_out1 != hist[j-3]) bad2++;
            snd_in1 = 12'h100 + 12'(j);
            hist[j] = snd_in1;
        end
        chk("div1_stb_continuous", 32'(bad), 32'd0);
        chk("div1_passthrough", 32'(bad2), 32'd0);
        chk("div1_last_value", 32'(snd_out1), 32'h100 + 32'd37);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fds_snd_filter.md
Name: fds_snd_filter

Overview:
- Post-processing stage that sits directly downstream of the FDS sound generator.
- Consumes the generator's 12-bit unsigned volume output and applies a first-order IIR low-pass, which models the FDS RC output filter.
- Updates at a fixed internal sample rate derived from the block clock.
- Drives a registered 12-bit sample to the mixer, plus a 1-bit first-order sigma-delta (PDM) stream for a direct audio pin.

Parameters:
- W, 12, sample width of snd_in/snd_out.
- DIV, 24, clk cycles per filter update (legal range 1..65535).
- SHIFT, 4, filter coefficient exponent: alpha = 2^-SHIFT (legal range 0..8).

Ports:
- clk  in  1  block clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- snd_in  in  W  unsigned sample from the FDS sound generator.
- bypass  in  1  1 = filter bypassed; raw captured sample forwarded.
- snd_out  out  W  filtered (or bypassed) sample, registered.
- smp_stb  out  1  one-cycle pulse, high in the cycle snd_out takes a new value.
- pdm_out  out  1  sigma-delta bitstream of snd_out, registered.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: div_ctr, x_r, acc, snd_out, pdm_acc, stage flags = 0; smp_stb = 0; pdm_out = 0. Assertion mid-pipeline discards any in-flight update; no stale smp_stb after release.
- Divider: div_ctr counts 0..DIV-1 and wraps to 0. upd = (div_ctr == DIV-1). With DIV=1, upd is high every cycle.
- Pipeline, three registered stages, fully overlapped so back-to-back upd (DIV=1) is legal:
  - Cycle T (upd=1): x_r <= snd_in; byp_r <= bypass; s1 <= 1.
  - T+1 (s1=1): acc <= acc - (acc >> SHIFT) + x_r; s2 <= 1.
  - T+2 (s2=1): snd_out <= byp_r ? x_r_d : acc[W+SHIFT-1:SHIFT]; smp_stb = 1 for this single cycle. x_r_d is x_r delayed one stage.
  - Latency from snd_in capture to snd_out: 2 cycles.
- Arithmetic:
  - acc is unsigned, W+SHIFT bits, and holds y * 2^SHIFT.
  - Subtraction precedes addition within full width. The result is provably bounded by (2^W - 1) << SHIFT, so there is no overflow and no saturation logic.
  - Truncation only (floor); no rounding.
  - SHIFT=0: acc = x_r, so the filter acts as a 2-cycle passthrough.
- Bypass:
  - Sampled only at upd.
  - acc keeps updating while bypassed, so un-bypassing resumes from the tracked state with no step.
  - Toggling between updates has no effect until the next upd.
- PDM, runs every clk independently of upd:
  - pdm_acc is W+1 bits. pdm_acc <= {1'b0, pdm_acc[W-1:0]} + snd_out; pdm_out <= carry of that add, i.e. bit W of the new sum.
  - Long-run density of ones = snd_out / 2^W.
  - snd_out = 0 gives constant 0. 2^W - 1 gives one zero per 2^W clocks.
- Simultaneous events: an upd coinciding with s2 of the previous update (DIV <= 2) is handled by the independent stage registers; every update produces exactly one smp_stb.

Test Plan:
- Step response: DIV=24, SHIFT=4, reset, snd_in=0x800 held.
  - -> 1st smp_stb snd_out=128, 2nd=248, 3rd=360.
  - smp_stb exactly every 24 clocks; first pulse 2 cycles after first upd.
- Full scale: snd_in=0xFFF held for 400 updates -> snd_out monotonic non-decreasing, reaches 0xFFF and stays; acc never exceeds 0xFFFF.
- Bypass: filter settled at 0, bypass=1, snd_in=0x321.
  - -> next smp_stb snd_out=0x321.
  - bypass=0 at next update -> snd_out equals acc-derived value, not 0.
- PDM density: force steady snd_out=0x400 -> pdm_out pattern 0001 repeating (1 of 4 clocks). snd_out=0 -> pdm_out always 0.
- Reset mid-operation: assert rst in cycle T+1 of an update.
  - -> snd_out=0, smp_stb=0, pdm_out=0 immediately (asynchronous).
  - After release, first smp_stb occurs DIV+1 clocks later.
- DIV=1, SHIFT=0: snd_in ramps +1 per clock -> smp_stb high continuously; snd_out equals snd_in delayed 2 clocks.
